// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and baud divider helpers.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int calc_div(input int clk_freq, input int baud_rate, input int over_samples);
    return clk_freq / (baud_rate * over_samples);
  endfunction

  function automatic int calc_div_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk pulse every DIV clocks, shared by RX and TX.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVER_SAMPLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVER_SAMPLES);
  localparam int W   = calc_div_w(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority vote per bit, valid/ready output
// port with framing/parity flags and a sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVER_SAMPLES = 16,
  parameter int DATA_BIT     = 8,
  parameter int PARITY_BIT   = 0,
  parameter int STOP_BIT     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [DATA_BIT-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun
);

  logic                tick;
  logic                rx_meta_q, rx_s_q;
  rx_state_e           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [1:0]          smp_q, smp_d;
  logic                ferr_q, ferr_d, perr_q, perr_d;
  logic                vote, commit;
  logic [DATA_BIT-1:0] dout_q, dout_d;
  logic                dv_q, dv_d, fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;

  uart_baud_tick #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .OVER_SAMPLES(OVER_SAMPLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Samples from cnt 7 and 8 are held; the cnt 9 sample is used live.
  assign vote = maj3(smp_q[0], smp_q[1], rx_s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    commit  = 1'b0;
    if (tick) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7) smp_d[0] = rx_s_q;
      if (cnt_q == 4'd8) smp_d[1] = rx_s_q;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = START;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (cnt_q == 4'd7 && rx_s_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == 4'd15) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          if (cnt_q == 4'd9) shift_d = {vote, shift_q[DATA_BIT-1:1]};
          if (cnt_q == 4'd15) begin
            if (idx_q == 3'(DATA_BIT - 1)) begin
              idx_d   = '0;
              state_d = (PARITY_BIT != PARITY_NONE) ? PARITY : STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (cnt_q == 4'd9) perr_d = (^shift_q ^ vote) != (PARITY_BIT == PARITY_ODD);
          if (cnt_q == 4'd15) state_d = STOP;
        end
        STOP: begin
          if (cnt_q == 4'd9) begin
            if (!vote) ferr_d = 1'b1;
            // Commit mid-bit so a back-to-back start edge is never missed.
            if (idx_q == 3'(STOP_BIT - 1)) begin
              commit  = 1'b1;
              cnt_d   = '0;
              idx_d   = '0;
              state_d = ferr_d ? BREAK : IDLE;
            end
          end else if (cnt_q == 4'd15) begin
            idx_d = idx_q + 3'd1;
          end
        end
        BREAK: begin
          cnt_d = '0;
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    fe_d   = fe_q;
    pe_d   = pe_q;
    ov_d   = ov_q;
    if (commit) begin
      if (!dv_q || data_ready) begin
        dout_d = shift_q;
        fe_d   = ferr_d;
        pe_d   = perr_q;
        dv_d   = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (dv_q && data_ready) begin
      dv_d = 1'b0;
      ov_d = 1'b0;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: an 8N1 instance and an 8E1 instance,
// each fed by a bit-level line driver and checked against frame-level expectations.
module tb_uart_rx;

  localparam int CLK_FREQ = 6400;
  localparam int BAUD     = 100;
  localparam int BIT_CLKS = 64;  // 16 ticks * DIV(4)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] do_a, do_b;
  logic       dv_a, dv_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  int checks = 0;
  int errors = 0;
  int dv_cyc_a = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVER_SAMPLES(16),
            .DATA_BIT(8), .PARITY_BIT(0), .STOP_BIT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_out(do_a), .data_valid(dv_a),
    .data_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVER_SAMPLES(16),
            .DATA_BIT(8), .PARITY_BIT(2), .STOP_BIT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_out(do_b), .data_valid(dv_b),
    .data_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  // Accepted words, recorded as {frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (dv_a) dv_cyc_a++;
    if (dv_a && ready_a) qa.push_back({fe_a, pe_a, do_a});
    if (dv_b && ready_b) qb.push_back({fe_b, pe_b, do_b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic bitw();
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // par < 0: no parity bit. Stop level is held for 1+hold bit times, then idle high.
  task automatic send(input bit sel, input logic [7:0] d, input int par,
                      input logic stop, input int hold, input int idle_bits);
    drive(sel, 1'b0); bitw();
    for (int i = 0; i < 8; i++) begin drive(sel, d[i]); bitw(); end
    if (par >= 0) begin drive(sel, par[0]); bitw(); end
    drive(sel, stop); bitw();
    repeat (hold) bitw();
    drive(sel, 1'b1);
    repeat (idle_bits) bitw();
  endtask

  task automatic get_word(input bit sel, input string tag, output logic [9:0] w);
    int n = 0;
    while (((sel ? qb.size() : qa.size()) == 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    if ((sel ? qb.size() : qa.size()) == 0) begin
      checks++; errors++;
      $error("FAIL %s: timeout waiting for word, observed none expected one", tag);
      w = 'x;
    end else begin
      w = sel ? qb.pop_front() : qa.pop_front();
    end
  endtask

  task automatic expect_word(input bit sel, input string tag, input logic [7:0] d,
                             input logic fe, input logic pe);
    logic [9:0] w;
    get_word(sel, tag, w);
    check({tag, " data"}, w[7:0], d);
    check({tag, " frame_err"}, w[9], fe);
    check({tag, " parity_err"}, w[8], pe);
  endtask

  function automatic logic even_perr(input logic [7:0] d, input logic p);
    return ($countones({d, p}) % 2) != 0;
  endfunction

  initial begin
    logic [7:0] d;
    logic       p, stp;

    repeat (5) @(negedge clk);
    check("reset data_out", do_a, 8'h00);
    check("reset data_valid", dv_a, 1'b0);
    check("reset frame_err", fe_a, 1'b0);
    check("reset parity_err", pe_a, 1'b0);
    check("reset overrun", ov_a, 1'b0);
    check("reset b data_valid", dv_b, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send(0, 8'hA5, -1, 1'b1, 0, 1);
    expect_word(0, "8n1 a5", 8'hA5, 1'b0, 1'b0);
    check("a5 valid width", dv_cyc_a, 1);

    // Start-bit glitch of 3 ticks
    rx_a = 1'b0; repeat (12) @(negedge clk); rx_a = 1'b1;
    bitw(); bitw();
    check("glitch no word", qa.size(), 0);
    check("glitch no valid", dv_a, 1'b0);
    send(0, 8'h3C, -1, 1'b1, 0, 1);
    expect_word(0, "after glitch 3c", 8'h3C, 1'b0, 1'b0);

    // Framing error followed by a long break
    send(0, 8'h81, -1, 1'b0, 3, 0);
    check("break one word", qa.size(), 1);
    expect_word(0, "break 81", 8'h81, 1'b1, 1'b0);
    bitw();
    send(0, 8'h42, -1, 1'b1, 0, 1);
    expect_word(0, "after break 42", 8'h42, 1'b0, 1'b0);

    send(1, 8'h03, 1, 1'b1, 0, 1);
    expect_word(1, "even par1", 8'h03, 1'b0, 1'b1);
    send(1, 8'h03, 0, 1'b1, 0, 1);
    expect_word(1, "even par0", 8'h03, 1'b0, 1'b0);

    // Overrun: back-to-back frames with no consumer
    ready_a = 1'b0;
    send(0, 8'h11, -1, 1'b1, 0, 0);
    send(0, 8'h22, -1, 1'b1, 0, 1);
    check("ovr valid", dv_a, 1'b1);
    check("ovr data_out", do_a, 8'h11);
    check("ovr overrun", ov_a, 1'b1);
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1 ready_a = 1'b0;
    @(negedge clk);
    check("ovr clr valid", dv_a, 1'b0);
    check("ovr clr overrun", ov_a, 1'b0);
    expect_word(0, "ovr accepted", 8'h11, 1'b0, 1'b0);
    check("ovr single accept", qa.size(), 0);
    ready_a = 1'b1;

    // Reset in the middle of a frame
    fork
      send(0, 8'hFF, -1, 1'b1, 0, 2);
      begin
        repeat (BIT_CLKS * 4 + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst data_out", do_a, 8'h00);
        check("midrst valid", dv_a, 1'b0);
        check("midrst frame_err", fe_a, 1'b0);
        check("midrst overrun", ov_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("midrst no word", qa.size(), 0);
    send(0, 8'h5A, -1, 1'b1, 0, 1);
    expect_word(0, "after rst 5a", 8'h5A, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      send(0, d, -1, stp, 0, 1);
      expect_word(0, $sformatf("rand a%0d", i), d, !stp, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      send(1, d, int'(p), 1'b1, 0, 1);
      expect_word(1, $sformatf("rand b%0d", i), d, 1'b0, even_perr(d, p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone UART receiver: deserializes an asynchronous `rx` line into DATA_BIT-wide words using 16x oversampling with 3-sample majority voting, then presents each word on a valid/ready output port together with framing and parity error flags. It sits between the board `rx` pin and the consumer logic, such as an echo loop, a command decoder or a FIFO. It is the receive half paired with the existing UART transmitter and shares its baud parameters and tick generator.

## Interface
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bps.
- OVER_SAMPLES, 16: ticks per bit. Fixed at 16.
- DATA_BIT, 8: data bits per frame, legal range 5..8. Sent LSB first.
- PARITY_BIT, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BIT, 1: stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock. One clock domain; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rx  in  1  serial line, asynchronous to clk, idle high.
- data_out  out  DATA_BIT  received word. Stable while data_valid=1.
- data_valid  out  1  word available. Held until accepted.
- data_ready  in  1  consumer accepts the word in any cycle where data_valid=1.
- frame_err  out  1  a stop bit sampled 0. Qualified by data_valid.
- parity_err  out  1  parity mismatch. Qualified by data_valid. Always 0 when PARITY_BIT=0.
- overrun  out  1  sticky flag: a completed frame was dropped.

## Operation
- Input synchronization: `rx` passes through a 2-FF synchronizer to produce rx_s. Both flops reset to 1.
- Baud tick: DIV = CLK_FREQ/(BAUD_RATE*OVER_SAMPLES), integer division (54 at the defaults). A free-running counter cycles 0..DIV-1 and asserts tick for one clk when it reaches DIV-1.
- State flow per tick. The 4-bit sample counter `cnt` runs 0..15 within each bit.
- IDLE: rx_s=0 → START, cnt=0.
- START: at cnt=7, if rx_s=1 → IDLE (glitch rejection, nothing is reported). At cnt=15 → DATA, cnt=0, idx=0.
- DATA: record rx_s at cnt 7, 8 and 9. At cnt=9 the majority value is shifted into the shift register LSB-first. At cnt=15: if idx=DATA_BIT-1, go to PARITY when PARITY_BIT≠0, otherwise STOP; else idx+1.
- PARITY: majority vote at cnt=9; perr = (XOR of data bits ^ vote) != (PARITY_BIT==1). At cnt=15 → STOP.
- STOP: majority vote at cnt=9 of each stop bit; any vote of 0 sets ferr.
  - Commit happens at cnt=9 of the final stop bit, without waiting for the rest of the bit.
  - After commit: ferr=0 → IDLE; ferr=1 → BREAK.
- BREAK: stay until rx_s=1 on a tick, then → IDLE. A held-low line therefore yields exactly one word.
- Commit with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle:
  - data_out is loaded from the shift register.
  - frame_err and parity_err are loaded from ferr and perr.
  - data_valid is set to 1.
- Commit with data_valid=1 and data_ready=0: the new word is discarded, data_out and the error flags keep their old values, and overrun is set to 1.
- Handshake with no commit in the same cycle: data_valid=1 and data_ready=1 clears data_valid and overrun.

## Timing
- Reset: all outputs 0, state IDLE, all counters 0, shift register 0.
- Asserting rst_n=0 mid-frame aborts the frame immediately and no partial word is delivered. After release the receiver waits in IDLE for the next falling edge.
- Bit period is 16*DIV clks (864 at the defaults, -0.46% from ideal).
- Start-edge detection latency is 2 sync cycles plus at most DIV clks.
- Outputs are registered: data_valid rises 1 clk after the tick at cnt=9 of the final stop bit.
- The earliest next-frame start edge detectable is the tick after commit. Back-to-back frames need no idle gap.
- data_ready is ignored while data_valid=0. There is no combinational path from data_ready to any output.

## Structure
- Package `uart_pkg`:
  - Parity mode constants PARITY_NONE/ODD/EVEN.
  - rx state enum IDLE/START/DATA/PARITY/STOP/BREAK.
  - Function computing DIV and its counter width.
- Sub-module `uart_baud_tick` (parameters CLK_FREQ, BAUD_RATE, OVER_SAMPLES; output tick). Instantiated once here and reused by the transmitter.
- The synchronizer, FSM, shift register and output register stay inline.

## Test plan
- 8N1 at default parameters, send 0xA5, data_ready=1 → data_out=0xA5, data_valid high for 1 clk, frame_err=0, parity_err=0.
- rx low for 3 ticks then high → no data_valid, FSM back in IDLE; a following frame 0x3C is received correctly.
- Send 0x81 with stop bit 0, then hold rx low for 3 bit times → exactly one word: data_out=0x81, frame_err=1. The next frame is received only after rx returns high.
- PARITY_BIT=2, send 0x03 with parity bit 1 → parity_err=1. Repeat with parity bit 0 → parity_err=0.
- data_ready=0, back-to-back frames 0x11 then 0x22 → data_out=0x11, overrun=1. A single data_ready pulse clears both data_valid and overrun.
- Drop rst_n for 1 clk in the middle of frame 0xFF → all outputs 0 immediately. The next frame 0x5A is received as 0x5A with no errors.
